// File: rtl/onectr_chunked_if.sv
// Handshake/bus bundle for onectr_chunked. ONECTR_FIRSTONE_EN adds the
// lowest-set-bit result signals (firstone_o, found_o).
interface onectr_chunked_if #(
  parameter int INPUTSIZE = 64
);
  localparam int OW = $clog2(INPUTSIZE + 1);
  localparam int FW = (INPUTSIZE > 1) ? $clog2(INPUTSIZE) : 1;

  logic                 start_i;
  logic                 mode_i;
  logic [INPUTSIZE-1:0] inport;
  logic                 ready_o;
  logic                 done_o;
  logic [OW-1:0]        outport;
`ifdef ONECTR_FIRSTONE_EN
  logic [FW-1:0]        firstone_o;
  logic                 found_o;

  modport master (output start_i, mode_i, inport,
                  input  ready_o, done_o, outport, firstone_o, found_o);
  modport slave  (input  start_i, mode_i, inport,
                  output ready_o, done_o, outport, firstone_o, found_o);
`else
  modport master (output start_i, mode_i, inport,
                  input  ready_o, done_o, outport);
  modport slave  (input  start_i, mode_i, inport,
                  output ready_o, done_o, outport);
`endif
endinterface

// File: rtl/onectr_chunked.sv
// Multi-cycle ones/zeros counter: CHUNKSIZE bits per cycle over an INPUTSIZE word.
// Optional ONECTR_FIRSTONE_EN also reports the index of the lowest set bit.
module onectr_chunked #(
  parameter int INPUTSIZE = 64,
  parameter int CHUNKSIZE = 8
) (
  input logic              clk,
  input logic              rst,
  onectr_chunked_if.slave  bus
);
  localparam int NCHUNK = INPUTSIZE / CHUNKSIZE;
  localparam int OW     = $clog2(INPUTSIZE + 1);
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int FW     = (INPUTSIZE > 1) ? $clog2(INPUTSIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [INPUTSIZE-1:0] sr_q, sr_d, sr_shift;
  logic [OW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OW-1:0]        out_q, out_d;
  logic                 done_q, done_d;
  logic [CHUNKSIZE-1:0] chunk;
  logic                 ready, capture, step, finish;

  function automatic logic [OW-1:0] popcnt(input logic [CHUNKSIZE-1:0] v);
    logic [OW-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNKSIZE; i++) c = c + OW'(v[i]);
    return c;
  endfunction

  assign chunk = sr_q[CHUNKSIZE-1:0];

  // A single-chunk word has nothing left above the chunk to shift down.
  generate
    if (NCHUNK == 1) begin : g_noshift
      assign sr_shift = '0;
    end else begin : g_shift
      assign sr_shift = {{CHUNKSIZE{1'b0}}, sr_q[INPUTSIZE-1:CHUNKSIZE]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_i) state_d = S_COUNT;
      S_COUNT: if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready   = (state_q == S_IDLE);
    capture = ready && bus.start_i;
    step    = (state_q == S_COUNT);
    finish  = (state_q == S_DONE);
  end

  always_comb begin
    sr_d   = sr_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    done_d = 1'b0;
    if (capture) begin
      // Zero counting is ones counting on the inverted word.
      sr_d  = bus.mode_i ? ~bus.inport : bus.inport;
      acc_d = '0;
      cnt_d = '0;
    end else if (step) begin
      sr_d  = sr_shift;
      acc_d = acc_q + popcnt(chunk);
      cnt_d = cnt_q + CW'(1);
    end else if (finish) begin
      out_d  = acc_q;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.done_o  = done_q;
  assign bus.outport = out_q;

`ifdef ONECTR_FIRSTONE_EN
  logic [FW-1:0] fo_q, fo_d, fo_out_q, fo_out_d;
  logic          found_q, found_d, found_out_q, found_out_d;
  logic [FW-1:0] base;

  function automatic logic [FW-1:0] lowidx(input logic [CHUNKSIZE-1:0] v);
    logic [FW-1:0] r;
    r = '0;
    for (int i = CHUNKSIZE - 1; i >= 0; i--) if (v[i]) r = FW'(i);
    return r;
  endfunction

  // Chunks arrive low-first, so the first non-empty chunk holds the lowest set bit.
  assign base = FW'(cnt_q) * FW'(CHUNKSIZE);

  always_comb begin
    fo_d        = fo_q;
    found_d     = found_q;
    fo_out_d    = fo_out_q;
    found_out_d = found_out_q;
    if (capture) begin
      fo_d    = '0;
      found_d = 1'b0;
    end else if (step) begin
      if (!found_q && (|chunk)) begin
        found_d = 1'b1;
        fo_d    = base + lowidx(chunk);
      end
    end else if (finish) begin
      fo_out_d    = fo_q;
      found_out_d = found_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fo_q        <= '0;
      found_q     <= 1'b0;
      fo_out_q    <= '0;
      found_out_q <= 1'b0;
    end else begin
      fo_q        <= fo_d;
      found_q     <= found_d;
      fo_out_q    <= fo_out_d;
      found_out_q <= found_out_d;
    end
  end

  assign bus.firstone_o = fo_out_q;
  assign bus.found_o    = found_out_q;
`endif
endmodule

// File: tb/tb_onectr_chunked.sv
// Scoreboard bench for onectr_chunked (64/8 main instance, 64/64 single-chunk instance).
module tb_onectr_chunked;
  localparam int NCHUNK = 8;

  logic clk, rst;
  int   tests, fails, cyc;
  logic mon_en;
  logic [6:0] exp_hold;

  typedef struct {
    logic [6:0] cnt;
    logic [5:0] fo;
    logic       found;
    int         acc_cyc;
  } exp_t;
  exp_t sb[$];

  onectr_chunked_if #(.INPUTSIZE(64)) bus ();
  onectr_chunked_if #(.INPUTSIZE(64)) bus2 ();

  onectr_chunked #(.INPUTSIZE(64), .CHUNKSIZE(8))  dut  (.clk(clk), .rst(rst), .bus(bus));
  onectr_chunked #(.INPUTSIZE(64), .CHUNKSIZE(64)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [63:0] d, input logic m, input int c);
    exp_t e;
    logic [63:0] w;
    w = m ? ~d : d;
    e.cnt = 7'($countones(w));
    e.fo = '0;
    e.found = 1'b0;
    for (int i = 63; i >= 0; i--) if (w[i]) begin e.fo = 6'(i); e.found = 1'b1; end
    e.acc_cyc = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en && rst) begin
      if (bus.done_o) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_done: done_o=1 at cycle %0d, no result outstanding", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          tests++;
          if (bus.outport !== e.cnt) begin
            fails++; $display("FAIL result: outport=%0d expected %0d", bus.outport, e.cnt);
          end
          tests++;
          if (cyc - e.acc_cyc !== NCHUNK + 1) begin
            fails++; $display("FAIL latency: done %0d edges after accept, expected %0d", cyc - e.acc_cyc, NCHUNK + 1);
          end
          tests++;
          if (bus.ready_o !== 1'b1) begin
            fails++; $display("FAIL ready_at_done: ready_o=%b expected 1", bus.ready_o);
          end
`ifdef ONECTR_FIRSTONE_EN
          tests++;
          if (bus.firstone_o !== e.fo || bus.found_o !== e.found) begin
            fails++; $display("FAIL firstone: fo=%0d found=%b expected fo=%0d found=%b",
                              bus.firstone_o, bus.found_o, e.fo, e.found);
          end
`endif
          exp_hold = e.cnt;
        end
      end else begin
        tests++;
        if (bus.outport !== exp_hold) begin
          fails++; $display("FAIL hold: outport=%0d expected %0d", bus.outport, exp_hold);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [63:0] d, input logic m);
    int guard;
    guard = 0;
    while (bus.ready_o !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      tests++; fails++; $display("FAIL ready_timeout: ready_o=%b expected 1", bus.ready_o);
    end
    bus.start_i = 1'b1; bus.inport = d; bus.mode_i = m;
    @(posedge clk); #1;
    sb.push_back(model(d, m, cyc));
    bus.start_i = 1'b0;
    bus.inport  = {$urandom, $urandom};
    bus.mode_i  = ~m;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start_i = 1'b1; bus.mode_i = 1'b0; bus.inport = '1;
    bus2.start_i = 1'b1; bus2.mode_i = 1'b0; bus2.inport = '1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: ready_o=%b expected 1", bus.ready_o); end
    tests++;
    if (bus.done_o !== 1'b0) begin fails++; $display("FAIL reset_done: done_o=%b expected 0", bus.done_o); end
    tests++;
    if (bus.outport !== 7'd0) begin fails++; $display("FAIL reset_out: outport=%0d expected 0", bus.outport); end
    tests++;
    if (bus2.ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready2: ready_o=%b expected 1", bus2.ready_o); end
`ifdef ONECTR_FIRSTONE_EN
    tests++;
    if (bus.found_o !== 1'b0 || bus.firstone_o !== 6'd0) begin
      fails++; $display("FAIL reset_firstone: fo=%0d found=%b expected 0/0", bus.firstone_o, bus.found_o);
    end
`endif
    bus.start_i = 1'b0; bus2.start_i = 1'b0;
    exp_hold = '0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue(64'h5555_5555_5555_5555, 1'b0);
    issue(64'h5555_5555_5555_5555, 1'b1);
    issue(64'h0000_0000_0000_00FF, 1'b1);
    issue(64'h0000_0000_0000_0100, 1'b0);
    issue(64'h0000_0000_0000_0000, 1'b0);
    issue(64'h0000_0000_0000_0000, 1'b1);
    issue(64'h8000_0000_0000_0000, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    logic m, r;
    bus.start_i = 1'b1;
    for (int i = 0; i < 45; i++) begin
      d = {$urandom, $urandom};
      m = 1'($urandom_range(0, 1));
      r = bus.ready_o;
      bus.inport = d; bus.mode_i = m;
      @(posedge clk); #1;
      if (r) sb.push_back(model(d, m, cyc));
    end
    bus.start_i = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_abort();
    issue(64'h0123_4567_89AB_CDEF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL abort_ready: ready_o=%b expected 1", bus.ready_o); end
    tests++;
    if (bus.outport !== 7'd0) begin fails++; $display("FAIL abort_out: outport=%0d expected 0", bus.outport); end
    sb.delete();
    exp_hold = '0;
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    issue(64'hF0F0_F0F0_F0F0_F0F0, 1'b0);
    wait_drain();
  endtask

  task automatic single_chunk(input logic [63:0] d, input logic [6:0] expv);
    int s, guard;
    bus2.start_i = 1'b1; bus2.inport = d; bus2.mode_i = 1'b0;
    @(posedge clk); #1;
    s = cyc;
    bus2.start_i = 1'b0;
    guard = 0;
    @(negedge clk);
    while (bus2.done_o !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    tests++;
    if (bus2.done_o !== 1'b1 || cyc - s !== 2) begin
      fails++; $display("FAIL single_chunk_latency: done_o=%b after %0d edges, expected 2", bus2.done_o, cyc - s);
    end
    tests++;
    if (bus2.outport !== expv) begin
      fails++; $display("FAIL single_chunk_result: outport=%0d expected %0d", bus2.outport, expv);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_chunk();
    single_chunk(64'h0, 7'd0);
    single_chunk(64'hFFFF_FFFF_FFFF_FFFF, 7'd64);
    single_chunk(64'h0000_0000_F000_0001, 7'd5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      issue({$urandom, $urandom} & {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; mon_en = 1'b0; exp_hold = '0;
    bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.inport = '0;
    bus2.start_i = 1'b0; bus2.mode_i = 1'b0; bus2.inport = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    mon_en = 1'b1;
    test_basic();
    test_back_to_back();
    test_reset_abort();
    test_single_chunk();
    test_random();
    repeat (12) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
